// File: rtl/clk_div_bank_pkg.sv
// rtl/clk_div_bank_pkg.sv - shared constants, event type and helpers for clk_div_bank
package clk_div_bank_pkg;

  localparam int DEF_W   = 10;
  localparam int DEF_NCH = 3;

  // What a channel's counter does on a given cycle
  typedef enum logic [1:0] {
    EV_HOLD,
    EV_COUNT,
    EV_RESTART
  } chan_ev_e;

  // Width of the channel-select field; never narrower than one bit
  function automatic int ch_w(input int nch);
    return (nch > 1) ? $clog2(nch) : 1;
  endfunction

  // First count value at which the square wave is high (low phase is the ceiling half)
  function automatic int unsigned hi_start(input int unsigned n);
    return n - n / 2;
  endfunction

endpackage

// File: rtl/clk_div_bank_if.sv
// rtl/clk_div_bank_if.sv - divisor configuration bus with pending-status return
interface clk_div_bank_if import clk_div_bank_pkg::*; #(
  parameter int NCH = DEF_NCH,
  parameter int W   = DEF_W
);

  localparam int CHW = ch_w(NCH);

  logic           cfg_we;
  logic [CHW-1:0] cfg_ch;
  logic [W-1:0]   cfg_div;
  logic [NCH-1:0] pend;

  modport master (output cfg_we, output cfg_ch, output cfg_div, input  pend);
  modport slave  (input  cfg_we, input  cfg_ch, input  cfg_div, output pend);

endinterface

// File: rtl/clk_div_bank_div_chan.sv
// rtl/clk_div_bank_div_chan.sv - one divider channel (tick output gated by CLK_DIV_BANK_TICK_EN)
module div_chan import clk_div_bank_pkg::*; #(
  parameter int           W       = DEF_W,
  parameter logic [W-1:0] DEF_DIV = W'(10)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         sync,
  input  logic         we,
  input  logic [W-1:0] wdata,
  output logic         pend,
  output logic         div_clk
`ifdef CLK_DIV_BANK_TICK_EN
  ,
  output logic         tick
`endif
);

  logic [W-1:0] n_q, n_d;
  logic [W-1:0] p_q, p_d;
  logic [W-1:0] cnt_q, cnt_d;
  logic         pend_q, pend_d;
  logic         div_clk_q, div_clk_d;
  logic         last_q, last_d;
  chan_ev_e     ev;

  // Classify the cycle, advance or restart the counter, apply/accept divisors, precompute outputs
  always_comb begin
    n_d    = n_q;
    p_d    = p_q;
    pend_d = pend_q;
    cnt_d  = cnt_q;
    ev     = EV_HOLD;

    // Period boundary, stopped channel (N==0) and sync all restart the period
    if (sync || (en && (last_q || (n_q == '0)))) begin
      ev = EV_RESTART;
    end else if (en) begin
      ev = EV_COUNT;
    end

    case (ev)
      EV_RESTART: begin
        cnt_d = '0;
        if (pend_q) begin
          n_d    = p_q;
          pend_d = 1'b0;
        end
      end
      EV_COUNT: cnt_d = cnt_q + W'(1);
      default:  cnt_d = cnt_q;
    endcase

    // A write after the apply decision: the old P is consumed, the new one waits
    if (we) begin
      p_d    = wdata;
      pend_d = 1'b1;
    end

    div_clk_d = (n_d >= W'(2)) && (32'(cnt_d) >= hi_start(32'(n_d)));
    last_d    = (n_d != '0) && (cnt_d == n_d - W'(1));
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      n_q       <= DEF_DIV;
      p_q       <= '0;
      cnt_q     <= '0;
      pend_q    <= 1'b0;
      div_clk_q <= 1'b0;
      last_q    <= (DEF_DIV == W'(1));
    end else begin
      n_q       <= n_d;
      p_q       <= p_d;
      cnt_q     <= cnt_d;
      pend_q    <= pend_d;
      div_clk_q <= div_clk_d;
      last_q    <= last_d;
    end
  end

  assign pend    = pend_q;
  assign div_clk = div_clk_q;
`ifdef CLK_DIV_BANK_TICK_EN
  assign tick    = en & last_q;
`endif

endmodule

// File: rtl/clk_div_bank.sv
// rtl/clk_div_bank.sv - multi-channel programmable divider bank (tick port under CLK_DIV_BANK_TICK_EN)
module clk_div_bank import clk_div_bank_pkg::*; #(
  parameter int               NCH      = DEF_NCH,
  parameter int               W        = DEF_W,
  parameter logic [NCH*W-1:0] DEF_DIVS = {10'd1000, 10'd100, 10'd10}
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               sync,
  clk_div_bank_if.slave      cfg,
`ifdef CLK_DIV_BANK_TICK_EN
  output logic [NCH-1:0]     tick,
`endif
  output logic [NCH-1:0]     div_clk
);

  logic [NCH-1:0] pend_vec;
  logic [NCH-1:0] div_clk_vec;
`ifdef CLK_DIV_BANK_TICK_EN
  logic [NCH-1:0] tick_vec;
`endif

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    // Out-of-range channel numbers match no channel, so those writes vanish
    logic we_i;
    assign we_i = cfg.cfg_we && (32'(cfg.cfg_ch) == i);

    div_chan #(
      .W       (W),
      .DEF_DIV (DEF_DIVS[i*W +: W])
    ) u_chan (
      .clk     (clk),
      .rst     (rst),
      .en      (en),
      .sync    (sync),
      .we      (we_i),
      .wdata   (cfg.cfg_div),
      .pend    (pend_vec[i]),
      .div_clk (div_clk_vec[i])
`ifdef CLK_DIV_BANK_TICK_EN
      ,
      .tick    (tick_vec[i])
`endif
    );
  end

  assign cfg.pend = pend_vec;
  assign div_clk  = div_clk_vec;
`ifdef CLK_DIV_BANK_TICK_EN
  assign tick     = tick_vec;
`endif

endmodule
